// File: rtl/logic_pkg.sv
// Shared definitions for the binary logic unit and its request arbiter:
// opcode constants and the arbiter FSM state encoding.
package logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational W-bit bitwise logic unit. NOT ignores operand b.
module logic_unit
  import logic_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  // Select the bitwise function named by the opcode.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two requesters.
// One operation in flight: IDLE grants, EXEC computes for one cycle,
// RESP holds the tagged result until the consumer accepts it.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [W-1:0]     resp_data,
  output logic             resp_id,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [W-1:0]     resp_data_q, resp_data_d;
  logic             resp_id_q, resp_id_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             winner_s;
  logic [1:0]       grant_s;
  logic             accept_s;
  logic [1:0]       sel_op_s;
  logic [W-1:0]     sel_a_s;
  logic [W-1:0]     sel_b_s;
  logic [W-1:0]     result_s;

  // Pick the arbitration winner; only the IDLE state ever grants.
  always_comb begin
    winner_s = 1'b0;
    grant_s  = 2'b00;
    if (req_valid == 2'b11) begin
      winner_s = ~last_grant_q;
    end else begin
      winner_s = req_valid[1];
    end
    if ((state_q == IDLE) && !rst && (req_valid != 2'b00)) begin
      grant_s = winner_s ? 2'b10 : 2'b01;
    end else begin
      grant_s = 2'b00;
    end
  end

  assign req_ready = grant_s;
  assign accept_s  = |(req_valid & grant_s);

  // Route only the winner's payload so an idle port's inputs never leak through.
  always_comb begin
    sel_op_s = req0_op;
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    if (winner_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  logic_unit #(
    .W(W)
  ) u_logic_unit (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result_s)
  );

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the latched request, response registers and counter.
  always_comb begin
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    ops_done_d   = ops_done_q;
    if ((state_q == IDLE) && accept_s) begin
      last_grant_d = winner_s;
      op_d         = sel_op_s;
      a_d          = sel_a_s;
      b_d          = sel_b_s;
      id_d         = winner_s;
    end else if (state_q == EXEC) begin
      resp_data_d  = result_s;
      resp_id_d    = id_q;
      resp_valid_d = 1'b1;
    end else if ((state_q == RESP) && resp_ready) begin
      resp_valid_d = 1'b0;
      ops_done_d   = ops_done_q + CNT_W'(1);
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // State register; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomised, self-checking bench for logic_unit_arbiter (W=4, CNT_W=2),
// with a transaction-level reference model and directed literal checks.
module tb_logic_unit_arbiter;

  localparam int W     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [1:0]       req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [W-1:0]     resp_data;
  logic             resp_id;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic_unit_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  // Transaction model: one job at most; age counts edges since acceptance.
  bit         m_job   = 1'b0;
  int         m_age   = 0;
  logic [3:0] m_res   = 4'd0;
  bit         m_id    = 1'b0;
  bit         m_last  = 1'b1;
  int         m_done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++) begin
      case (op)
        2'd0:    r[i] = a[i] && b[i];
        2'd1:    r[i] = a[i] || b[i];
        2'd2:    r[i] = a[i] != b[i];
        default: r[i] = !a[i];
      endcase
    end
    return r;
  endfunction

  function automatic bit pick();
    if (req_valid == 2'b11) return !m_last;
    return req_valid[1];
  endfunction

  function automatic logic [1:0] exp_ready();
    if (rst || m_job || req_valid == 2'b00) return 2'b00;
    return pick() ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_job = 1'b0; m_age = 0; m_res = 4'd0; m_id = 1'b0; m_last = 1'b1; m_done = 0;
  endtask

  task automatic model_step();
    bit w;
    if (m_job) begin
      if (m_age == 0) m_age = 1;
      else if (resp_ready) begin
        m_job  = 1'b0;
        m_done = (m_done + 1) % (1 << CNT_W);
      end
    end else if (req_valid != 2'b00) begin
      w      = pick();
      m_job  = 1'b1;
      m_age  = 0;
      m_id   = w;
      m_last = w;
      m_res  = w ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    bit ev;
    ev = m_job && (m_age == 1);
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready()});
    chk("ready_onehot", {31'd0, req_ready == 2'b11}, 32'd0);
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, m_job});
    chk("ops_done", {30'd0, ops_done}, m_done);
    if (ev) begin
      chk("resp_data", {28'd0, resp_data}, {28'd0, m_res});
      chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
    end
  end

  logic [3:0] datas[$];
  bit         ids[$];
  int         ops_seq[$];
  bit         prev_v;

  initial begin
    model_reset();
    req_valid = 2'b11;
    #3;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops", {30'd0, ops_done}, 32'd0);
    req_valid = 2'b00;
    do_reset();

    // OR on requester 0.
    resp_ready = 1'b1;
    req_valid = 2'b01; req0_op = 2'b01; req0_a = 4'b1001; req0_b = 4'b0101;
    cyc(); req_valid = 2'b00;
    chk("t1_exec_busy", {31'd0, busy}, 32'd1);
    chk("t1_exec_valid", {31'd0, resp_valid}, 32'd0);
    cyc();
    chk("t1_valid", {31'd0, resp_valid}, 32'd1);
    chk("t1_data", {28'd0, resp_data}, 32'hd);
    chk("t1_id", {31'd0, resp_id}, 32'd0);
    cyc();
    chk("t1_valid_off", {31'd0, resp_valid}, 32'd0);
    chk("t1_ops", {30'd0, ops_done}, 32'd1);

    // Requester 1: OR then AND.
    do_reset();
    req_valid = 2'b10; req1_op = 2'b01; req1_a = 4'b0011; req1_b = 4'b1100;
    cyc(); req_valid = 2'b00; cyc();
    chk("t2_or", {28'd0, resp_data}, 32'hf);
    chk("t2_or_id", {31'd0, resp_id}, 32'd1);
    cyc();
    req_valid = 2'b10; req1_op = 2'b00;
    cyc(); req_valid = 2'b00; cyc();
    chk("t2_and", {28'd0, resp_data}, 32'h0);
    chk("t2_and_id", {31'd0, resp_id}, 32'd1);
    cyc();
    chk("t2_ops", {30'd0, ops_done}, 32'd2);

    // Both requesters continuously; also exercises the CNT_W=2 wrap.
    do_reset();
    req_valid = 2'b11;
    req0_op = 2'b10; req0_a = 4'b1010; req0_b = 4'b0110;
    req1_op = 2'b11; req1_a = 4'b0001; req1_b = 4'b1011;
    prev_v = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (prev_v) ops_seq.push_back(int'(ops_done));
      if (resp_valid) begin
        ids.push_back(resp_id);
        datas.push_back(resp_data);
      end
      prev_v = resp_valid;
    end
    chk("t3_count", ids.size(), 32'd5);
    chk("t3_ops_count", ops_seq.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < ids.size()) begin
        chk("t3_id", {31'd0, ids[k]}, k % 2);
        chk("t3_data", {28'd0, datas[k]}, (k % 2 == 0) ? 32'hc : 32'he);
      end
      if (k < ops_seq.size())
        chk("t3_wrap", ops_seq[k], (k + 1) % 4);
    end
    req_valid = 2'b00;

    // Backpressure in RESP.
    do_reset();
    resp_ready = 1'b0;
    req_valid = 2'b01; req0_op = 2'b00; req0_a = 4'b1111; req0_b = 4'b0110;
    cyc(); req_valid = 2'b11; cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_valid", {31'd0, resp_valid}, 32'd1);
      chk("t4_data", {28'd0, resp_data}, 32'h6);
      chk("t4_id", {31'd0, resp_id}, 32'd0);
      chk("t4_ready", {30'd0, req_ready}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd1);
    end
    req_valid = 2'b00; resp_ready = 1'b1;
    cyc();
    chk("t4_done", {31'd0, resp_valid}, 32'd0);
    chk("t4_ops", {30'd0, ops_done}, 32'd1);

    // Reset while in EXEC.
    do_reset();
    req_valid = 2'b10; req1_op = 2'b01; req1_a = 4'b0101; req1_b = 4'b0000;
    cyc(); req_valid = 2'b00;
    rst = 1'b1; model_reset();
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, resp_valid}, 32'd0);
    cyc(); cyc();
    chk("t5_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("t5_ops", {30'd0, ops_done}, 32'd0);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("t5_prio", {30'd0, req_ready}, 32'd1);
    cyc(); req_valid = 2'b00; cyc();
    chk("t5_id", {31'd0, resp_id}, 32'd0);
    cyc();

    // Randomised traffic with idle-port X payloads and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) != 0);
      if (req_valid[0]) begin
        req0_op = 2'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      end else begin
        req0_op = 'x; req0_a = 'x; req0_b = 'x;
      end
      if (req_valid[1]) begin
        req1_op = 2'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      end else begin
        req1_op = 'x; req1_a = 'x; req1_b = 'x;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; model_reset();
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    req_valid = 2'b00;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
